// File: rtl/homog_pkg.sv
// ----------------------------------------------------------------------------
// homog_pkg
// Shared types and helpers for the homography projector.
//   - state_e           : sequencing FSM states (IDLE, MAC, DRAIN, DONE)
//   - WIDTH_DEF/FRAC_DEF: default coordinate width and coefficient fraction
//   - prod_width()      : signed product width derived from WIDTH (2*WIDTH+1)
//   - acc_width()       : signed accumulator width derived from WIDTH (2*WIDTH+3)
//   - ROW_X/ROW_Y/ROW_W : row index of H producing X, Y and W
//   - TERM_LAST         : index of the constant (third) term in a row
// ----------------------------------------------------------------------------
package homog_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int WIDTH_DEF = 14;
    localparam int FRAC_DEF  = 8;

    localparam logic [1:0] ROW_X     = 2'd0;
    localparam logic [1:0] ROW_Y     = 2'd1;
    localparam logic [1:0] ROW_W     = 2'd2;
    localparam logic [1:0] TERM_LAST = 2'd2;

    function automatic int prod_width(input int width);
        return 2 * width + 1;
    endfunction

    function automatic int acc_width(input int width);
        return 2 * width + 3;
    endfunction

endpackage

// File: rtl/homography_projector_clamp_shift.sv
// ----------------------------------------------------------------------------
// clamp_shift
// Scales an accumulated Q-format sum back to integer pixels (arithmetic shift
// right by FRAC) and saturates the result into the unsigned range
// [0, 2^WIDTH-1].
//   acc_i : signed accumulator value, ACC_W bits
//   res_o : clamped unsigned result, WIDTH bits
// ----------------------------------------------------------------------------
module clamp_shift #(
    parameter int WIDTH = 14,
    parameter int FRAC  = 8,
    parameter int ACC_W = 31
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic        [WIDTH-1:0] res_o
);

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((2 ** WIDTH) - 1);

    logic signed [ACC_W-1:0] shifted;

    // NOTE: every signal written in always_comb gets a value before any
    // condition, otherwise the missing paths would infer a latch.
    always_comb begin
        shifted = acc_i >>> FRAC;
        res_o   = shifted[WIDTH-1:0];
        if (shifted[ACC_W-1]) begin
            res_o = '0;
        end else if (shifted > MAX_V) begin
            res_o = '1;
        end
    end

endmodule

// File: rtl/homography_projector.sv
// ----------------------------------------------------------------------------
// homography_projector
// Maps NPTS pixel coordinates (u,v) through a 3x3 homography H with a single
// shared multiplier and presents the homogeneous numerators X,Y (dividends)
// and W (divisor) of every point to a downstream divider array. Outputs are
// held between results and only change on the valid_out cycle.
//
// Ports:
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   pause_in         : freezes all sequencing while high
//   start_in         : starts a projection when ready_out=1 and pause_in=0
//   ready_out        : high while idle
//   h_in             : H coefficients h0..h8 (row-major, signed Q FRAC)
//   u_in, v_in       : point coordinates (unsigned)
//   dividend_out     : [2p]=X_p, [2p+1]=Y_p
//   divisor_out      : [p]=W_p
//   valid_out        : one-cycle pulse when the outputs update
//   degenerate_out   : per-point flag, W <= 0 forced to 1 (only with
//                      HOMOG_W_GUARD_EN defined)
// ----------------------------------------------------------------------------
module homography_projector
    import homog_pkg::*;
#(
    parameter int NPTS  = 3,
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           pause_in,
    input  logic                           start_in,
    output logic                           ready_out,
    // Elements are reinterpreted as signed where they are used.
    input  logic [8:0][WIDTH-1:0]          h_in,
    input  logic [NPTS-1:0][WIDTH-1:0]     u_in,
    input  logic [NPTS-1:0][WIDTH-1:0]     v_in,
    output logic [2*NPTS-1:0][WIDTH-1:0]   dividend_out,
    output logic [NPTS-1:0][WIDTH-1:0]     divisor_out,
`ifdef HOMOG_W_GUARD_EN
    output logic [NPTS-1:0]                degenerate_out,
`endif
    output logic                           valid_out
);

    localparam int PROD_W = prod_width(WIDTH);
    localparam int ACC_W  = acc_width(WIDTH);
    localparam int PT_W   = (NPTS > 1) ? $clog2(NPTS) : 1;
    localparam logic [PT_W-1:0] PT_LAST = PT_W'(NPTS - 1);

    state_e                          state_q, state_d;
    logic [PT_W-1:0]                 pt_q, pt_d;
    logic [1:0]                      row_q, row_d, term_q, term_d;

    logic [8:0][WIDTH-1:0]           h_q;
    logic [NPTS-1:0][WIDTH-1:0]      u_q, v_q;

    // Tags travel with the product register so the landing term knows
    // which (pt,row,term) it belongs to.
    logic signed [PROD_W-1:0]        prod_q, prod_d;
    logic                            prod_vld_q;
    logic [PT_W-1:0]                 tag_pt_q;
    logic [1:0]                      tag_row_q, tag_term_q;
    logic signed [ACC_W-1:0]         acc_q, acc_sum;

    logic [2*NPTS-1:0][WIDTH-1:0]    stage_xy_q, stage_xy_d;
    logic [NPTS-1:0][WIDTH-1:0]      stage_w_q, stage_w_d;
    logic [2*NPTS-1:0][WIDTH-1:0]    dividend_q;
    logic [NPTS-1:0][WIDTH-1:0]      divisor_q;
    logic                            valid_q;
    logic [WIDTH-1:0]                clamped;

    logic [3:0]                      coef_idx;
    logic signed [WIDTH-1:0]         coef;
    logic signed [WIDTH:0]           operand;
    logic                            accept, land_last, publish;

`ifdef HOMOG_W_GUARD_EN
    logic [NPTS-1:0]                 stage_deg_q, stage_deg_d, deg_q;
    logic                            w_nonpos;
`endif

    assign accept    = (state_q == IDLE) && start_in && !pause_in;
    assign land_last = prod_vld_q && (tag_term_q == TERM_LAST) && !pause_in;
    assign publish   = (state_q == DONE) && !pause_in;

    // ---------------- FSM and issue counters ----------------
    always_comb begin
        state_d = state_q;
        pt_d    = pt_q;
        row_d   = row_q;
        term_d  = term_q;
        if (!pause_in) begin
            unique case (state_q)
                IDLE: begin
                    if (start_in) begin
                        state_d = MAC;
                        pt_d    = '0;
                        row_d   = ROW_X;
                        term_d  = '0;
                    end
                end
                MAC: begin
                    if (term_q == TERM_LAST) begin
                        term_d = '0;
                        if (row_q == ROW_W) begin
                            row_d = ROW_X;
                            if (pt_q == PT_LAST) begin
                                state_d = DRAIN;
                            end else begin
                                pt_d = pt_q + 1'b1;
                            end
                        end else begin
                            row_d = row_q + 2'd1;
                        end
                    end else begin
                        term_d = term_q + 2'd1;
                    end
                end
                DRAIN:   state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- Shared multiplier ----------------
    always_comb begin
        coef_idx = 4'(row_q) * 4'd3 + 4'(term_q);
        coef     = $signed(h_q[coef_idx]);
        unique case (term_q)
            2'd0:    operand = {1'b0, u_q[pt_q]};
            2'd1:    operand = {1'b0, v_q[pt_q]};
            default: operand = (WIDTH + 1)'(2 ** FRAC);
        endcase
        prod_d = PROD_W'(coef) * PROD_W'(operand);
    end

    // The first term of a row restarts the sum instead of adding to it.
    assign acc_sum = (tag_term_q == 2'd0) ? ACC_W'(prod_q)
                                          : acc_q + ACC_W'(prod_q);

    clamp_shift #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ACC_W (ACC_W)
    ) u_clamp_shift (
        .acc_i (acc_sum),
        .res_o (clamped)
    );

`ifdef HOMOG_W_GUARD_EN
    // (acc >>> FRAC) <= 0 is the same as acc < 2^FRAC.
    assign w_nonpos = acc_sum < ACC_W'(2 ** FRAC);
`endif

    // ---------------- Staging write on the third term ----------------
    always_comb begin
        stage_xy_d = stage_xy_q;
        stage_w_d  = stage_w_q;
`ifdef HOMOG_W_GUARD_EN
        stage_deg_d = stage_deg_q;
`endif
        if (land_last) begin
            for (int p = 0; p < NPTS; p++) begin
                if (tag_pt_q == PT_W'(p)) begin
                    unique case (tag_row_q)
                        ROW_X:   stage_xy_d[2*p]   = clamped;
                        ROW_Y:   stage_xy_d[2*p+1] = clamped;
                        default: begin
`ifdef HOMOG_W_GUARD_EN
                            stage_w_d[p]   = w_nonpos ? WIDTH'(1) : clamped;
                            stage_deg_d[p] = w_nonpos;
`else
                            stage_w_d[p] = clamped;
`endif
                        end
                    endcase
                end
            end
        end
    end

    // NOTE: sequential state is assigned with <= only, so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: the staging and output arrays are small and their reset value is
    // visible to the dividers, so they are reset like ordinary registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            pt_q        <= '0;
            row_q       <= '0;
            term_q      <= '0;
            h_q         <= '0;
            u_q         <= '0;
            v_q         <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            tag_pt_q    <= '0;
            tag_row_q   <= '0;
            tag_term_q  <= '0;
            acc_q       <= '0;
            stage_xy_q  <= '0;
            stage_w_q   <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            valid_q     <= 1'b0;
`ifdef HOMOG_W_GUARD_EN
            stage_deg_q <= '0;
            deg_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pt_q       <= pt_d;
            row_q      <= row_d;
            term_q     <= term_d;
            stage_xy_q <= stage_xy_d;
            stage_w_q  <= stage_w_d;
`ifdef HOMOG_W_GUARD_EN
            stage_deg_q <= stage_deg_d;
`endif
            if (accept) begin
                h_q <= h_in;
                u_q <= u_in;
                v_q <= v_in;
            end
            if (!pause_in) begin
                prod_vld_q <= (state_q == MAC);
                if (state_q == MAC) begin
                    prod_q     <= prod_d;
                    tag_pt_q   <= pt_q;
                    tag_row_q  <= row_q;
                    tag_term_q <= term_q;
                end
                if (prod_vld_q) begin
                    acc_q <= acc_sum;
                end
            end
            valid_q <= publish;
            if (publish) begin
                dividend_q <= stage_xy_q;
                divisor_q  <= stage_w_q;
`ifdef HOMOG_W_GUARD_EN
                deg_q      <= stage_deg_q;
`endif
            end
        end
    end

    assign ready_out    = (state_q == IDLE);
    assign valid_out    = valid_q;
    assign dividend_out = dividend_q;
    assign divisor_out  = divisor_q;
`ifdef HOMOG_W_GUARD_EN
    assign degenerate_out = deg_q;
`endif

endmodule

// File: tb/tb_homography_projector.sv
// ----------------------------------------------------------------------------
// tb_homography_projector
// Directed self-checking bench for homography_projector. Expected results are
// computed by a behavioural model at start time, queued, and compared when
// valid_out pulses. Build with HOMOG_W_GUARD_EN to cover degenerate_out.
// ----------------------------------------------------------------------------
module tb_homography_projector;

    localparam int NPTS = 3;
    localparam int W    = 14;
    localparam int FRAC = 8;
    localparam longint MAXV = (64'd1 << W) - 1;

    typedef logic [8:0][W-1:0]        h_t;
    typedef logic [NPTS-1:0][W-1:0]   pts_t;
    typedef logic [2*NPTS-1:0][W-1:0] div_t;

    typedef struct {
        div_t            dividend;
        pts_t            divisor;
        logic [NPTS-1:0] deg;
    } exp_t;

    logic clk_in, rst_n_in, pause_in, start_in, ready_out, valid_out;
    h_t   h_in;
    pts_t u_in, v_in, divisor_out;
    div_t dividend_out;
`ifdef HOMOG_W_GUARD_EN
    logic [NPTS-1:0] degenerate_out;
`endif

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    homography_projector #(.NPTS(NPTS), .WIDTH(W), .FRAC(FRAC)) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .pause_in     (pause_in),
        .start_in     (start_in),
        .ready_out    (ready_out),
        .h_in         (h_in),
        .u_in         (u_in),
        .v_in         (v_in),
        .dividend_out (dividend_out),
        .divisor_out  (divisor_out),
`ifdef HOMOG_W_GUARD_EN
        .degenerate_out (degenerate_out),
`endif
        .valid_out    (valid_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input h_t h, input pts_t u, input pts_t v);
        exp_t   e;
        longint acc, sh, res;
        e.dividend = '0;
        e.divisor  = '0;
        e.deg      = '0;
        for (int p = 0; p < NPTS; p++) begin
            for (int r = 0; r < 3; r++) begin
                acc = longint'($signed(h[3*r]))   * longint'(u[p])
                    + longint'($signed(h[3*r+1])) * longint'(v[p])
                    + longint'($signed(h[3*r+2])) * (64'sd1 <<< FRAC);
                sh  = acc >>> FRAC;
                res = (sh < 0) ? 0 : ((sh > MAXV) ? MAXV : sh);
`ifdef HOMOG_W_GUARD_EN
                if (r == 2 && sh <= 0) begin
                    res      = 1;
                    e.deg[p] = 1'b1;
                end
`endif
                if (r < 2) e.dividend[2*p+r] = W'(res);
                else       e.divisor[p]      = W'(res);
            end
        end
        return e;
    endfunction

    function automatic h_t mk_h(input int c0, input int c1, input int c2, input int c3,
                                input int c4, input int c5, input int c6, input int c7,
                                input int c8);
        h_t h;
        h[0] = W'(c0); h[1] = W'(c1); h[2] = W'(c2);
        h[3] = W'(c3); h[4] = W'(c4); h[5] = W'(c5);
        h[6] = W'(c6); h[7] = W'(c7); h[8] = W'(c8);
        return h;
    endfunction

    function automatic pts_t mk_p(input int a, input int b, input int c);
        pts_t p;
        p[0] = W'(a); p[1] = W'(b); p[2] = W'(c);
        return p;
    endfunction

    // One projection: accept, watch latency/ready/hold, then score the result.
    task automatic run_job(input string name, input h_t h, input pts_t u, input pts_t v,
                           input bit do_pause, input int exp_lat);
        int   n, pulses;
        logic hold_bad, ready_bad;
        div_t prev_div;
        pts_t prev_w;
        exp_t e;
        @(negedge clk_in);
        h_in = h; u_in = u; v_in = v; start_in = 1'b1;
        sb_q.push_back(model(h, u, v));
        @(posedge clk_in); #1;
        start_in = 1'b0;
        h_in = ~h; u_in = ~u; v_in = ~v;
        check({name, " ready_after_accept"}, 64'(ready_out), 64'd0);
        prev_div = dividend_out; prev_w = divisor_out;
        n = 0; hold_bad = 1'b0; ready_bad = 1'b0;
        while (n < 200) begin
            @(posedge clk_in); #1;
            n++;
            if (valid_out) break;
            if (ready_out) ready_bad = 1'b1;
            if (dividend_out !== prev_div || divisor_out !== prev_w) hold_bad = 1'b1;
            pause_in = do_pause && n >= 10 && n < 15;
            start_in = do_pause && n == 5;
        end
        pause_in = 1'b0; start_in = 1'b0;
        check({name, " latency"}, 64'(n), 64'(exp_lat));
        check({name, " ready_low_during"}, 64'(ready_bad), 64'd0);
        check({name, " outputs_held"}, 64'(hold_bad), 64'd0);
        if (valid_out) begin
            check({name, " ready_at_valid"}, 64'(ready_out), 64'd1);
            check({name, " sb_depth"}, 64'(sb_q.size()), 64'd1);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (valid_out) begin
                for (int i = 0; i < 2*NPTS; i++)
                    check($sformatf("%s dividend[%0d]", name, i), 64'(dividend_out[i]), 64'(e.dividend[i]));
                for (int i = 0; i < NPTS; i++)
                    check($sformatf("%s divisor[%0d]", name, i), 64'(divisor_out[i]), 64'(e.divisor[i]));
`ifdef HOMOG_W_GUARD_EN
                check({name, " degenerate"}, 64'(degenerate_out), 64'(e.deg));
`endif
            end
        end
        pulses = 0;
        repeat (12) begin
            @(posedge clk_in); #1;
            if (valid_out) pulses++;
        end
        check({name, " extra_pulses"}, 64'(pulses), 64'd0);
    endtask

    initial begin
        int   pulses;
        h_t   hr;
        pts_t ur, vr;
        rst_n_in = 1'b0; pause_in = 1'b0; start_in = 1'b0;
        h_in = '0; u_in = '0; v_in = '0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset ready", 64'(ready_out), 64'd1);
        check("reset valid", 64'(valid_out), 64'd0);
        check("reset dividend", 64'(|dividend_out), 64'd0);
        check("reset divisor", 64'(|divisor_out), 64'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        run_job("identity", mk_h(256, 0, 0, 0, 256, 0, 0, 0, 256),
                mk_p(10, 100, 1000), mk_p(20, 200, 2000), 1'b0, 9*NPTS + 2);
        run_job("scale", mk_h(512, 0, 0, 0, 512, 0, 0, 0, 512),
                mk_p(10, 100, 1000), mk_p(20, 200, 2000), 1'b0, 29);
        run_job("clamp_low", mk_h(256, 0, -50, 0, 256, 0, 0, 0, 256),
                mk_p(10, 100, 1000), mk_p(20, 200, 2000), 1'b0, 29);
        run_job("clamp_high", mk_h(8191, 0, 0, 0, 256, 0, 0, 0, 256),
                mk_p(1000, 5, 7), mk_p(3, 4, 9), 1'b0, 29);
        run_job("pause_start", mk_h(300, -20, 40, 15, 250, -30, 1, -2, 300),
                mk_p(500, 1200, 33), mk_p(700, 80, 4000), 1'b1, 34);

        // Reset in the middle of a projection: immediate abort, no pulse.
        @(negedge clk_in);
        h_in = mk_h(256, 0, 0, 0, 256, 0, 0, 0, 256);
        u_in = mk_p(1, 2, 3); v_in = mk_p(4, 5, 6); start_in = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        repeat (12) @(posedge clk_in);
        #1;
        rst_n_in = 1'b0;
        #1;
        check("midreset dividend", 64'(|dividend_out), 64'd0);
        check("midreset divisor", 64'(|divisor_out), 64'd0);
        check("midreset ready", 64'(ready_out), 64'd1);
        check("midreset valid", 64'(valid_out), 64'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk_in); #1;
            if (valid_out) pulses++;
        end
        check("midreset pulses", 64'(pulses), 64'd0);

        run_job("after_reset", mk_h(512, 0, 0, 0, 512, 0, 0, 0, 512),
                mk_p(10, 100, 1000), mk_p(20, 200, 2000), 1'b0, 29);
        run_job("w_zero", mk_h(0, 0, 0, 0, 0, 0, 0, 0, 0),
                mk_p(10, 100, 1000), mk_p(20, 200, 2000), 1'b0, 29);
        run_job("w_negative", mk_h(256, 0, 0, 0, 256, 0, 0, -3, 10),
                mk_p(10, 100, 1000), mk_p(20, 200, 2000), 1'b0, 29);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 9; i++) hr[i] = W'(int'($urandom_range(0, 800)) - 400);
            for (int i = 0; i < NPTS; i++) begin
                ur[i] = W'($urandom_range(0, 4000));
                vr[i] = W'($urandom_range(0, 4000));
            end
            run_job($sformatf("random%0d", k), hr, ur, vr, 1'b0, 29);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
